// File: rtl/mul_issue_pkg.sv
// Shared M-extension define header plus the packed-operation layout used by
// mul_issue and the mul/div unit.
`ifndef MUL_SHARED_DEFINES
`define MUL_SHARED_DEFINES
`define RB 1
`define RP (1 << `RB)
`define MUL_EXEPARAM_DW (13 + 3 * (5 + `RB))
`endif

package mul_issue_pkg;

  localparam int RB      = `RB;
  localparam int RP      = `RP;
  localparam int REG_W   = 5 + RB;
  localparam int OP_N    = 13;
  localparam int RF_N    = 32 * RP;
  localparam int MUL_DW  = `MUL_EXEPARAM_DW;

  // Packed layout, LSB first: rs2, rs1, rd0, then the one-hot op field.
  localparam int RS2_OFF = 0;
  localparam int RS1_OFF = REG_W;
  localparam int RD0_OFF = 2 * REG_W;
  localparam int OP_OFF  = 3 * REG_W;

  // Bit index of each operation inside the one-hot op field.
  typedef enum int unsigned {
    OP_MUL    = 0,
    OP_MULH   = 1,
    OP_MULHSU = 2,
    OP_MULHU  = 3,
    OP_DIV    = 4,
    OP_DIVU   = 5,
    OP_REM    = 6,
    OP_REMU   = 7,
    OP_MULW   = 8,
    OP_DIVW   = 9,
    OP_DIVUW  = 10,
    OP_REMW   = 11,
    OP_REMUW  = 12
  } mul_op_e;

  function automatic logic [REG_W-1:0] rs1_of(input logic [MUL_DW-1:0] info);
    return info[RS1_OFF +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] rs2_of(input logic [MUL_DW-1:0] info);
    return info[RS2_OFF +: REG_W];
  endfunction

endpackage

// File: rtl/mul_issue_if.sv
// Dispatch-side and executor-side handshake bundle of the mul/div issue queue.
interface mul_issue_if #(
  parameter int DW = mul_issue_pkg::MUL_DW
);
  logic          dispat_vaild;
  logic          dispat_ready;
  logic [DW-1:0] dispat_info;
  logic          mul_exeparam_vaild;
  logic [DW-1:0] mul_exeparam;
  logic          mul_execute_ready;

  modport slave (
    input  dispat_vaild, dispat_info, mul_execute_ready,
    output dispat_ready, mul_exeparam_vaild, mul_exeparam
  );

  modport master (
    output dispat_vaild, dispat_info, mul_execute_ready,
    input  dispat_ready, mul_exeparam_vaild, mul_exeparam
  );
endinterface

// File: rtl/gen_dffr.sv
// Generic flop cell with asynchronous active-low reset to zero.
module gen_dffr #(
  parameter int DW = 1
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) qout <= '0;
    else       qout <= dnxt;
  end
endmodule

// File: rtl/mul_issue_fifo.sv
// In-order storage for mul_issue: entry array plus wrap-bit read/write pointers.
module mul_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = mul_issue_pkg::MUL_DW
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wptr, rptr, wptr_nxt, rptr_nxt;
  logic          we;
  logic [DW-1:0] mem [DEPTH];

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign we    = push & ~full & ~flush;
  assign head  = mem[rptr[AW-1:0]];

  // Flush rewinds both pointers; the array contents are left stale.
  always_comb begin
    wptr_nxt = wptr;
    rptr_nxt = rptr;
    if (flush) begin
      wptr_nxt = '0;
      rptr_nxt = '0;
    end else begin
      if (we)           wptr_nxt = wptr + (AW+1)'(1);
      if (pop && !empty) rptr_nxt = rptr + (AW+1)'(1);
    end
  end

  gen_dffr #(.DW(AW+1)) u_wptr (.CLK(CLK), .RSTn(RSTn), .dnxt(wptr_nxt), .qout(wptr));
  gen_dffr #(.DW(AW+1)) u_rptr (.CLK(CLK), .RSTn(RSTn), .dnxt(rptr_nxt), .qout(rptr));

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic wr;
    assign wr = we && (wptr[AW-1:0] == AW'(i));
    gen_dffr #(.DW(DW)) u_ent (
      .CLK(CLK), .RSTn(RSTn), .dnxt(wr ? wdata : mem[i]), .qout(mem[i])
    );
  end
endmodule

// File: rtl/mul_issue.sv
// Issue queue in front of the mul/div unit: holds dispatched M-ops in order and
// issues the head once its sources are written back. Option: MUL_ISSUE_BYPASS_EN.
module mul_issue
  import mul_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = `MUL_EXEPARAM_DW
) (
  input  logic            CLK,
  input  logic            RSTn,
  mul_issue_if.slave      bus,
  input  logic [RF_N-1:0] rf_rdy,
  input  logic            flush
);
  logic          full, empty, push, fifo_push, pop, head_rdy, issue, vaild_q;
  logic [DW-1:0] head, issue_data, param_q, param_nxt;

  assign bus.dispat_ready = ~full;
  assign push     = bus.dispat_vaild & ~full & ~flush;
  assign head_rdy = rf_rdy[rs1_of(head)] & rf_rdy[rs2_of(head)];

  // The executor's ready only drops a cycle after it sees a pulse, so the
  // cycle holding vaild_q must not be treated as idle.
  assign pop = ~empty & head_rdy & bus.mul_execute_ready & ~vaild_q & ~flush;

`ifdef MUL_ISSUE_BYPASS_EN
  logic byp;
  assign byp = empty & push & rf_rdy[rs1_of(bus.dispat_info)] & rf_rdy[rs2_of(bus.dispat_info)]
             & bus.mul_execute_ready & ~vaild_q;
  assign fifo_push  = push & ~byp;
  assign issue      = pop | byp;
  assign issue_data = byp ? bus.dispat_info : head;
`else
  assign fifo_push  = push;
  assign issue      = pop;
  assign issue_data = head;
`endif

  assign param_nxt = issue ? issue_data : param_q;

  gen_dffr #(.DW(1))  u_vaild (.CLK(CLK), .RSTn(RSTn), .dnxt(issue),     .qout(vaild_q));
  gen_dffr #(.DW(DW)) u_param (.CLK(CLK), .RSTn(RSTn), .dnxt(param_nxt), .qout(param_q));

  assign bus.mul_exeparam_vaild = vaild_q;
  assign bus.mul_exeparam       = param_q;

  mul_issue_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .flush (flush),
    .push  (fifo_push),
    .pop   (pop),
    .wdata (bus.dispat_info),
    .head  (head),
    .full  (full),
    .empty (empty)
  );
endmodule
